// File: rtl/multicycle_main_control.sv
// Multi-cycle main control FSM for the 16-bit MIPS core: sequences fetch/decode/execute/memory/writeback.
// Optional retired-instruction counter enabled by defining CTRL_PERF_CNT_EN.
module multicycle_main_control #(
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        opcode,
    input  logic              zero,
    input  logic              mem_ready,
    output logic [2:0]        alu_op,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        pc_src,
    output logic              pc_write,
    output logic              ir_write,
    output logic              iord,
    output logic              mem_read,
    output logic              mem_write,
    output logic              reg_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              illegal,
    output logic [3:0]        cur_state,
    output logic [PERF_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_EXEC_BR  = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_ANDI = 4'd2;
    localparam logic [3:0] OP_ORI  = 4'd3;
    localparam logic [3:0] OP_NORI = 4'd4;
    localparam logic [3:0] OP_BEQ  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_SLTI = 4'd7;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;
    localparam logic [3:0] OP_J    = 4'd10;

    state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_R:                                        state_d = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_NORI, OP_SLTI:  state_d = S_EXEC_I;
                    OP_LW, OP_SW:                                state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                              state_d = S_EXEC_BR;
                    OP_J:                                        state_d = S_JUMP;
                    default:                                     state_d = S_TRAP;
                endcase
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_WB_R:     state_d = S_FETCH;
            S_EXEC_I:   state_d = S_WB_I;
            S_WB_I:     state_d = S_FETCH;
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
            S_WB_MEM:   state_d = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_EXEC_BR:  state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Moore decode of the state register; only the fetch/branch PC and IR strobes look at inputs.
    always_comb begin
        alu_op     = 3'b000;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'b11;
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b100;
            end
            S_WB_R: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                unique case (opcode)
                    OP_ADDI: alu_op = 3'b110;
                    OP_ANDI: alu_op = 3'b011;
                    OP_ORI:  alu_op = 3'b111;
                    OP_NORI: alu_op = 3'b001;
                    OP_SLTI: alu_op = 3'b101;
                    default: alu_op = 3'b000;
                endcase
            end
            S_WB_I:     reg_write = 1'b1;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC_BR: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
                pc_src    = 2'b01;
                pc_write  = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            S_TRAP:     illegal = 1'b1;
            default: ;
        endcase
    end

    assign cur_state = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic [PERF_W-1:0] cnt_q, cnt_d;
    logic              retire;

    always_comb begin
        retire = (state_d == S_FETCH) &&
                 (state_q inside {S_WB_R, S_WB_I, S_WB_MEM, S_MEM_WR, S_EXEC_BR, S_JUMP});
        cnt_d  = cnt_q + PERF_W'(retire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign instr_cnt = cnt_q;
`else
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed, table-driven bench for multicycle_main_control plus hand sequences for reset, trap and counting.
module tb_multicycle_main_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  opcode = 4'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic [2:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  pc_src;
    logic        pc_write, ir_write, iord, mem_read, mem_write;
    logic        reg_write, reg_dst, mem_to_reg, illegal;
    logic [3:0]  cur_state;
    logic [15:0] instr_cnt;

    int errors = 0;
    int checks = 0;

    multicycle_main_control #(.PERF_W(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .cur_state(cur_state),
        .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        z;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] o;
    } vec_t;

    vec_t vq[$];

    function automatic logic [16:0] ov(input int alu, input int a, input int b, input int ps,
                                       input int pcw, input int irw, input int io, input int mr,
                                       input int mw, input int rw, input int rd, input int m2r,
                                       input int ill);
        return {alu[2:0], a[0], b[1:0], ps[1:0], pcw[0], irw[0], io[0], mr[0], mw[0],
                rw[0], rd[0], m2r[0], ill[0]};
    endfunction

    function automatic logic [16:0] outs();
        return {alu_op, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, iord, mem_read,
                mem_write, reg_write, reg_dst, mem_to_reg, illegal};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] op, input logic z, input logic mr,
                       input logic [3:0] st, input logic [16:0] o);
        vec_t v;
        v.op = op; v.z = z; v.mr = mr; v.st = st; v.o = o;
        vq.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in FETCH with mem_ready high; checks latency back to FETCH.
    task automatic run_instr(input logic [3:0] op, input int exp_lat);
        int n;
        opcode = op; mem_ready = 1'b1; zero = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (cur_state != 4'd1 && n < 20);
        chk($sformatf("latency_op%0d", op), 32'(n), 32'(exp_lat));
    endtask

    // Mutual-exclusion invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((mem_read && mem_write) || (reg_write && pc_write)) begin
                errors++;
                $display("FAIL exclusive_strobes: mr=%0b mw=%0b rw=%0b pcw=%0b required no overlap",
                         mem_read, mem_write, reg_write, pc_write);
            end
        end
    end

    initial begin
        logic [16:0] O_F1, O_F0, O_DEC, O_EXR, O_WBR, O_WBI, O_MA, O_MRD, O_WBM, O_MWR, O_J, O_TRAP;
        logic [3:0]  iops [5];
        int          ialu [5];
        logic [15:0] exp_cnt;

        O_F1   = ov(0,0,1,0, 1,1,0,1, 0,0,0,0, 0);
        O_F0   = ov(0,0,1,0, 0,0,0,1, 0,0,0,0, 0);
        O_DEC  = ov(0,0,3,0, 0,0,0,0, 0,0,0,0, 0);
        O_EXR  = ov(4,1,0,0, 0,0,0,0, 0,0,0,0, 0);
        O_WBR  = ov(0,0,0,0, 0,0,0,0, 0,1,1,0, 0);
        O_WBI  = ov(0,0,0,0, 0,0,0,0, 0,1,0,0, 0);
        O_MA   = ov(0,1,2,0, 0,0,0,0, 0,0,0,0, 0);
        O_MRD  = ov(0,0,0,0, 0,0,1,1, 0,0,0,0, 0);
        O_WBM  = ov(0,0,0,0, 0,0,0,0, 0,1,0,1, 0);
        O_MWR  = ov(0,0,0,0, 0,0,1,0, 1,0,0,0, 0);
        O_J    = ov(0,0,0,2, 1,0,0,0, 0,0,0,0, 0);
        O_TRAP = ov(0,0,0,0, 0,0,0,0, 0,0,0,0, 1);
        iops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7};
        ialu = '{6, 3, 7, 1, 5};

        add(4'd0, 0, 1, 4'd0, 17'd0);
        add(4'd0, 0, 0, 4'd1, O_F0);
        add(4'd0, 0, 1, 4'd1, O_F1);
        add(4'd0, 0, 1, 4'd2, O_DEC);
        add(4'd0, 0, 1, 4'd3, O_EXR);
        add(4'd0, 0, 1, 4'd4, O_WBR);
        for (int k = 0; k < 5; k++) begin
            add(iops[k], 0, 1, 4'd1, O_F1);
            add(iops[k], 0, 1, 4'd2, O_DEC);
            add(iops[k], 0, 1, 4'd5, ov(ialu[k],1,2,0, 0,0,0,0, 0,0,0,0, 0));
            add(iops[k], 0, 1, 4'd6, O_WBI);
        end
        add(4'd8, 0, 1, 4'd1, O_F1);
        add(4'd8, 0, 1, 4'd2, O_DEC);
        add(4'd8, 0, 1, 4'd7, O_MA);
        add(4'd8, 0, 0, 4'd8, O_MRD);
        add(4'd8, 0, 0, 4'd8, O_MRD);
        add(4'd8, 0, 0, 4'd8, O_MRD);
        add(4'd8, 0, 1, 4'd8, O_MRD);
        add(4'd8, 0, 1, 4'd9, O_WBM);
        add(4'd9, 0, 1, 4'd1, O_F1);
        add(4'd9, 0, 1, 4'd2, O_DEC);
        add(4'd9, 0, 1, 4'd7, O_MA);
        add(4'd9, 0, 0, 4'd10, O_MWR);
        add(4'd9, 0, 1, 4'd10, O_MWR);
        add(4'd5, 1, 1, 4'd1, O_F1);
        add(4'd5, 1, 1, 4'd2, O_DEC);
        add(4'd5, 1, 1, 4'd11, ov(2,1,0,1, 1,0,0,0, 0,0,0,0, 0));
        add(4'd5, 0, 1, 4'd1, O_F1);
        add(4'd5, 0, 1, 4'd2, O_DEC);
        add(4'd5, 0, 1, 4'd11, ov(2,1,0,1, 0,0,0,0, 0,0,0,0, 0));
        add(4'd6, 0, 1, 4'd1, O_F1);
        add(4'd6, 0, 1, 4'd2, O_DEC);
        add(4'd6, 0, 1, 4'd11, ov(2,1,0,1, 1,0,0,0, 0,0,0,0, 0));
        add(4'd6, 1, 1, 4'd1, O_F1);
        add(4'd6, 1, 1, 4'd2, O_DEC);
        add(4'd6, 1, 1, 4'd11, ov(2,1,0,1, 0,0,0,0, 0,0,0,0, 0));
        add(4'd10, 0, 1, 4'd1, O_F1);
        add(4'd10, 0, 1, 4'd2, O_DEC);
        add(4'd10, 0, 1, 4'd12, O_J);
        add(4'd12, 0, 1, 4'd1, O_F1);
        add(4'd12, 0, 1, 4'd2, O_DEC);
        add(4'd12, 0, 1, 4'd15, O_TRAP);

        // Reset state, then release just after an edge.
        step();
        step();
        chk("reset_state", 32'(cur_state), 32'd0);
        chk("reset_outs", 32'(outs()), 32'd0);
        chk("reset_cnt", 32'(instr_cnt), 32'd0);
        rst = 1'b0;

        foreach (vq[i]) begin
            opcode = vq[i].op; zero = vq[i].z; mem_ready = vq[i].mr;
            #1;
            chk($sformatf("vec%0d_state", i), 32'(cur_state), 32'(vq[i].st));
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vq[i].o));
            step();
        end

        for (int k = 0; k < 20; k++) begin
            chk("trap_hold_state", 32'(cur_state), 32'd15);
            chk("trap_hold_illegal", 32'(illegal), 32'd1);
            step();
        end
`ifdef CTRL_PERF_CNT_EN
        exp_cnt = 16'd13;
`else
        exp_cnt = 16'd0;
`endif
        chk("table_cnt", 32'(instr_cnt), 32'(exp_cnt));

        // Reset out of TRAP, then R, lw, j counted, then illegal holds the count.
        rst = 1'b1;
        #1;
        chk("trap_reset_state", 32'(cur_state), 32'd0);
        chk("trap_reset_illegal", 32'(illegal), 32'd0);
        step();
        rst = 1'b0;
        mem_ready = 1'b1;
        chk("idle_after_release", 32'(cur_state), 32'd0);
        step();
        chk("fetch_after_idle", 32'(cur_state), 32'd1);
        run_instr(4'd0, 4);
        run_instr(4'd8, 5);
        run_instr(4'd10, 3);
`ifdef CTRL_PERF_CNT_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        chk("cnt_after_three", 32'(instr_cnt), 32'(exp_cnt));
        opcode = 4'd12;
        step();
        step();
        chk("illegal_trap_state", 32'(cur_state), 32'd15);
        for (int k = 0; k < 20; k++) begin
            chk("trap_illegal", 32'(illegal), 32'd1);
            chk("trap_cnt_frozen", 32'(instr_cnt), 32'(exp_cnt));
            step();
        end

        // Reset asserted in the middle of a stalled memory read.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("fetch_before_lw", 32'(cur_state), 32'd1);
        opcode = 4'd8;
        mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        step();
        step();
        chk("stalled_mem_rd", 32'(cur_state), 32'd8);
        chk("stalled_mem_rd_outs", 32'(outs()), 32'(O_MRD));
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_state", 32'(cur_state), 32'd0);
        chk("async_reset_outs", 32'(outs()), 32'd0);
        chk("async_reset_cnt", 32'(instr_cnt), 32'd0);
        step();
        rst = 1'b0;
        mem_ready = 1'b1;
        chk("idle_once", 32'(cur_state), 32'd0);
        step();
        chk("fetch_after_reset", 32'(cur_state), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multi-cycle main control FSM for the 16-bit MIPS core.
- Sequences each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Drives the datapath strobes and the 3-bit alu_op consumed by alu_control.
- Sits between the instruction register (opcode source) and the datapath muxes, register file, memory port and alu_control.

Parameters:
PERF_W, 16, width of the optional retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
opcode  input  4  IR[15:12]; stable from DECODE until the next IR write
zero  input  1  ALU zero flag
mem_ready  input  1  memory handshake; access completes in any cycle it is high
alu_op  output  3  to alu_control
alu_src_a  output  1  0=PC, 1=rs
alu_src_b  output  2  00=rt, 01=const 2, 10=sign-ext imm, 11=sign-ext imm<<1
pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target
pc_write  output  1  PC load
ir_write  output  1  IR load
iord  output  1  0=PC addresses memory, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_write  output  1  register file write
reg_dst  output  1  0=rt, 1=rd
mem_to_reg  output  1  0=ALUOut, 1=MDR
illegal  output  1  sticky illegal-opcode flag
cur_state  output  4  state encoding, for debug/verification
instr_cnt  output  PERF_W  retired instructions (optional feature)

Behaviour:
- Opcodes:
  - 0000 R-type, 0001 addi, 0010 andi, 0011 ori, 0100 nori, 0101 beq, 0110 bne, 0111 slti, 1000 lw, 1001 sw, 1010 j.
  - 1011-1111 are illegal.
- alu_op mapping:
  - lw/sw/address/PC add = 000, nori 001, beq/bne 010, andi 011, R-type 100, slti 101, addi 110, ori 111.
- State encodings:
  - IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, WB_R 4, EXEC_I 5, WB_I 6, MEM_ADDR 7, MEM_RD 8, WB_MEM 9, MEM_WR 10, EXEC_BR 11, JUMP 12, TRAP 15.
- Output model:
  - Outputs are decoded from the state register (Moore), except the strobes gated by mem_ready/zero as noted below.
  - Any output not listed for a state is 0.
- Reset:
  - Asserting rst forces state IDLE immediately, including mid-instruction or mid-memory-access.
  - During reset all outputs are 0, illegal=0 and instr_cnt=0.
  - IDLE lasts exactly one cycle after rst deasserts, then goes to FETCH.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00.
  - ir_write and pc_write are each equal to mem_ready.
  - If mem_ready -> DECODE, else hold (unbounded wait).
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=000 (computes the branch target into ALUOut).
  - Next state: R -> EXEC_R; addi/andi/ori/nori/slti -> EXEC_I; lw/sw -> MEM_ADDR; beq/bne -> EXEC_BR; j -> JUMP; illegal -> TRAP.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=100 -> WB_R.
- WB_R: reg_dst=1, reg_write=1, mem_to_reg=0 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op per mapping -> WB_I.
- WB_I: reg_dst=0, reg_write=1 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000 -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD:
  - Drives mem_read=1, iord=1.
  - If mem_ready -> WB_MEM, else hold.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WR:
  - Drives mem_write=1, iord=1.
  - If mem_ready -> FETCH, else hold.
  - mem_write stays high for every wait cycle.
- EXEC_BR:
  - Drives alu_src_a=1, alu_src_b=00, alu_op=010, pc_src=01.
  - pc_write = (beq & zero) | (bne & ~zero).
  - Next state -> FETCH.
- JUMP: pc_src=10, pc_write=1 -> FETCH.
- TRAP:
  - illegal=1; all other strobes 0.
  - Remains in TRAP until rst.
- Latency with mem_ready tied high:
  - R/I-type 4 cycles, lw 5, sw 4, beq/bne 3, j 3.
- Never asserted together in the same cycle: mem_read and mem_write; reg_write and pc_write.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- When defined:
  - instr_cnt increments by 1 on each transition into FETCH from WB_R, WB_I, WB_MEM, MEM_WR, EXEC_BR or JUMP.
  - It wraps modulo 2^PERF_W and clears on rst.
- When undefined:
  - instr_cnt is constant 0 and no counter register exists.

Test Plan:
- Reset: rst=1 mid-MEM_RD -> cur_state=0 in the same cycle, all outputs 0; after release, IDLE for 1 cycle then FETCH.
- R-type: opcode=0000, mem_ready=1 -> states 1,2,3,4,1; alu_op=100 in EXEC_R; reg_write=1, reg_dst=1 only in WB_R.
- I-type sweep: opcodes 0001/0010/0011/0100/0111 -> alu_op in EXEC_I = 110/011/111/001/101 respectively; WB_I has reg_dst=0.
- lw with 3 wait cycles on mem_ready in MEM_RD -> mem_read=1, iord=1 held 4 cycles, then WB_MEM with mem_to_reg=1; 8 cycles total. sw -> mem_write only, no reg_write.
- Branches: beq with zero=1 -> pc_write=1, pc_src=01 in EXEC_BR; beq with zero=0 -> pc_write=0; bne with zero=0 -> pc_write=1. j -> pc_src=10, pc_write=1.
- Illegal opcode 1100 -> TRAP (15), illegal=1 held for 20 cycles; with CTRL_PERF_CNT_EN defined, instr_cnt=3 after an R-type, a lw and a j, and it does not increment in TRAP.
